// File: rtl/arb4_priority_ctrl.sv
// 4-requester arbiter with fixed-priority or descending round-robin selection.
// A holder keeps the resource until it releases, or until the hold timeout
// expires while another requester is waiting. Grant outputs are registered.
module arb4_priority_ctrl #(
   parameter int MAX_HOLD = 4,
   parameter int CNT_W    = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   input  logic       mode,
   output logic [3:0] gnt,
   output logic [1:0] gnt_id,
   output logic       gnt_valid
);

   typedef enum logic [0:0] {IDLE, GRANT} state_t;

   // Last count value before a forced hand-over. With MAX_HOLD == 0 the
   // counter stays at zero and the timeout path is disabled.
   localparam int HOLD_LAST_I = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_LAST_I);

   state_t           state_q, state_d;
   logic [3:0]       gnt_q, gnt_d;
   logic [1:0]       gnt_id_q, gnt_id_d;
   logic             gnt_valid_q, gnt_valid_d;
   logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
   logic [1:0]       rr_ptr_q, rr_ptr_d;

   logic [3:0] others;
   logic       release_w;
   logic       timeout_w;
   logic [3:0] cand;
   logic       arb_go;
   logic [2:0] win;

   // Returns {found, index}. Fixed mode: highest set bit wins.
   // Round-robin: search ptr, ptr-1, ... (mod 4), first set bit wins.
   function automatic logic [2:0] arbitrate(input logic [3:0] c,
                                            input logic       m,
                                            input logic [1:0] ptr);
      logic       found;
      logic [1:0] idx;
      logic [1:0] pos;
      found = 1'b0;
      idx   = 2'd0;
      if (!m) begin
         for (int k = 0; k < 4; k++) begin
            if (c[k]) begin
               found = 1'b1;
               idx   = 2'(k);
            end
         end
      end else begin
         for (int k = 0; k < 4; k++) begin
            pos = ptr - 2'(k);
            if (!found && c[pos]) begin
               found = 1'b1;
               idx   = pos;
            end
         end
      end
      return {found, idx};
   endfunction

   // Next-state logic: decide whether to arbitrate, then load the winner or go idle.
   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      gnt_id_d    = gnt_id_q;
      gnt_valid_d = gnt_valid_q;
      hold_cnt_d  = hold_cnt_q;
      rr_ptr_d    = rr_ptr_q;
      cand        = 4'b0000;
      arb_go      = 1'b0;

      others    = req & ~(4'b0001 << gnt_id_q);
      release_w = ~req[gnt_id_q];
      timeout_w = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST) && (|others);

      case (state_q)
         IDLE: begin
            if (|req) begin
               cand   = req;
               arb_go = 1'b1;
            end
         end
         GRANT: begin
            // Release and timeout both mask only the current holder.
            if (release_w || timeout_w) begin
               cand   = others;
               arb_go = 1'b1;
            end else if (hold_cnt_q != HOLD_LAST) begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      win = arbitrate(cand, mode, rr_ptr_q);

      if (arb_go) begin
         hold_cnt_d = '0;
         if (win[2]) begin
            state_d     = GRANT;
            gnt_d       = 4'b0001 << win[1:0];
            gnt_id_d    = win[1:0];
            gnt_valid_d = 1'b1;
            if (mode) begin
               rr_ptr_d = win[1:0] - 2'd1;
            end
         end else begin
            state_d     = IDLE;
            gnt_d       = 4'b0000;
            gnt_id_d    = 2'd0;
            gnt_valid_d = 1'b0;
         end
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         gnt_q       <= 4'b0000;
         gnt_id_q    <= 2'd0;
         gnt_valid_q <= 1'b0;
         hold_cnt_q  <= '0;
         rr_ptr_q    <= 2'd3;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         gnt_id_q    <= gnt_id_d;
         gnt_valid_q <= gnt_valid_d;
         hold_cnt_q  <= hold_cnt_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   assign gnt       = gnt_q;
   assign gnt_id    = gnt_id_q;
   assign gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_arb4_priority_ctrl.sv
// Bench for arb4_priority_ctrl: behavioural model checked every cycle plus
// directed scenarios with hand-computed grant sequences.
module tb_arb4_priority_ctrl;

   localparam int MAX_HOLD = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] req = 4'b0000;
   logic       mode = 1'b0;
   logic [3:0] gnt;
   logic [1:0] gnt_id;
   logic       gnt_valid;

   int tests  = 0;
   int errors = 0;

   arb4_priority_ctrl #(.MAX_HOLD(MAX_HOLD), .CNT_W(3)) dut (
      .clk(clk), .rst(rst), .req(req), .mode(mode),
      .gnt(gnt), .gnt_id(gnt_id), .gnt_valid(gnt_valid)
   );

   always #5 clk = ~clk;

   // Model: who holds the resource, for how many cycles, and where RR searches next.
   int holder = -1;
   int held   = 0;
   int ptr    = 3;
   bit model_ok = 1'b0;

   function automatic int choose(input logic [3:0] c, input logic m, input int p);
      int r;
      r = -1;
      if (!m) begin
         for (int i = 3; i >= 0; i--) if (r < 0 && c[i]) r = i;
      end else begin
         for (int k = 0; k < 4; k++) if (r < 0 && c[(p - k + 4) % 4]) r = (p - k + 4) % 4;
      end
      return r;
   endfunction

   always @(posedge clk) begin
      logic [3:0] others;
      int w;
      if (rst) begin
         holder = -1; held = 0; ptr = 3; model_ok = 1'b1;
      end else if (holder < 0) begin
         if (req != 0) begin
            w = choose(req, mode, ptr);
            holder = w; held = 1;
            if (mode) ptr = (w + 3) % 4;
         end
      end else begin
         others = req & ~(4'b0001 << holder);
         if (!req[holder] || (held >= MAX_HOLD && others != 0)) begin
            if (others != 0) begin
               w = choose(others, mode, ptr);
               holder = w; held = 1;
               if (mode) ptr = (w + 3) % 4;
            end else begin
               holder = -1; held = 0;
            end
         end else begin
            held++;
         end
      end
   end

   // Every-cycle comparison against the model, plus output invariants.
   always @(negedge clk) begin
      logic [3:0] eg;
      logic [1:0] ei;
      if (model_ok) begin
         eg = (holder < 0) ? 4'b0000 : (4'b0001 << holder);
         ei = (holder < 0) ? 2'd0 : 2'(holder);
         tests++;
         if (gnt !== eg || gnt_id !== ei || gnt_valid !== (holder >= 0)) begin
            errors++;
            $display("FAIL model t=%0t gnt=%b id=%0d v=%b expected gnt=%b id=%0d v=%b",
                     $time, gnt, gnt_id, gnt_valid, eg, ei, holder >= 0);
         end
         tests++;
         if (gnt_valid !== (|gnt) || (!gnt_valid && gnt_id !== 2'd0) || ($countones(gnt) > 1)) begin
            errors++;
            $display("FAIL invariant t=%0t gnt=%b id=%0d v=%b", $time, gnt, gnt_id, gnt_valid);
         end
      end
   end

   task automatic tick(input logic [3:0] r, input logic m, input logic rs);
      @(negedge clk);
      req = r; mode = m; rst = rs;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [3:0] g, input logic [1:0] id, input logic v);
      tests++;
      if (gnt !== g || gnt_id !== id || gnt_valid !== v) begin
         errors++;
         $display("FAIL %s gnt=%b id=%0d v=%b expected gnt=%b id=%0d v=%b",
                  name, gnt, gnt_id, gnt_valid, g, id, v);
      end
   endtask

   int seq_fix[12] = '{3,3,3,3,2,2,2,2,3,3,3,3};
   int seq_rr[20]  = '{3,3,3,3,2,2,2,2,1,1,1,1,0,0,0,0,3,3,3,3};

   initial begin
      // Reset then idle.
      tick(4'b0000, 1'b0, 1'b1);
      chk("reset", 4'b0000, 2'd0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick(4'b0000, 1'b0, 1'b0);
         chk("idle", 4'b0000, 2'd0, 1'b0);
      end

      // Fixed priority, all requesting: 3 and 2 ping-pong on timeout.
      for (int i = 0; i < 12; i++) begin
         tick(4'b1111, 1'b0, 1'b0);
         chk($sformatf("fixed_all[%0d]", i), 4'b0001 << seq_fix[i], 2'(seq_fix[i]), 1'b1);
      end
      tick(4'b0000, 1'b0, 1'b0);
      chk("fixed_drop", 4'b0000, 2'd0, 1'b0);

      // Round-robin from reset pointer, all requesting.
      tick(4'b0000, 1'b1, 1'b1);
      for (int i = 0; i < 20; i++) begin
         tick(4'b1111, 1'b1, 1'b0);
         chk($sformatf("rr_all[%0d]", i), 4'b0001 << seq_rr[i], 2'(seq_rr[i]), 1'b1);
      end
      tick(4'b0000, 1'b1, 1'b0);

      // No preemption: requester 3 waits for requester 0 to release.
      tick(4'b0001, 1'b0, 1'b0);
      chk("np_grant0", 4'b0001, 2'd0, 1'b1);
      tick(4'b0001, 1'b0, 1'b0);
      tick(4'b1001, 1'b0, 1'b0);
      chk("np_hold_a", 4'b0001, 2'd0, 1'b1);
      tick(4'b1001, 1'b0, 1'b0);
      chk("np_hold_b", 4'b0001, 2'd0, 1'b1);
      tick(4'b1000, 1'b0, 1'b0);
      chk("np_handover", 4'b1000, 2'd3, 1'b1);
      tick(4'b0000, 1'b0, 1'b0);
      chk("np_idle", 4'b0000, 2'd0, 1'b0);

      // Lone holder is never forced off.
      for (int i = 0; i < 10; i++) begin
         tick(4'b0100, 1'b0, 1'b0);
         chk($sformatf("lone[%0d]", i), 4'b0100, 2'd2, 1'b1);
      end
      tick(4'b0000, 1'b0, 1'b0);
      chk("lone_release", 4'b0000, 2'd0, 1'b0);

      // Reset mid-grant, then RR restarts at requester 3.
      tick(4'b0010, 1'b0, 1'b0);
      chk("pre_reset", 4'b0010, 2'd1, 1'b1);
      tick(4'b0010, 1'b0, 1'b1);
      chk("mid_reset", 4'b0000, 2'd0, 1'b0);
      tick(4'b1111, 1'b1, 1'b0);
      chk("rr_after_reset", 4'b1000, 2'd3, 1'b1);

      // Mixed patterns and mode changes, checked by the model only.
      for (int i = 0; i < 40; i++) begin
         tick(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0);
      end
      tick(4'b0101, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) tick(4'b0101, 1'b1, 1'b0);
      tick(4'b0110, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) tick(4'b0110, 1'b1, 1'b0);
      tick(4'b0000, 1'b0, 1'b0);
      chk("final_idle", 4'b0000, 2'd0, 1'b0);

      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
